// File: rtl/cacheline_burst_adaptor_if.sv
// Cache-side and memory-side signals of the cacheline burst adaptor.
// slave: adaptor view; master: the cache/memory environment view.
interface cacheline_burst_adaptor_if #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64
);
  logic [31:0]        line_addr_i;
  logic               line_read_i;
  logic               line_write_i;
  logic [LINE_W-1:0]  line_wdata_i;
  logic [LINE_W-1:0]  line_rdata_o;
  logic               line_resp_o;
  logic [31:0]        mem_addr_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic [BURST_W-1:0] mem_wdata_o;
  logic [BURST_W-1:0] mem_rdata_i;
  logic               mem_resp_i;

  modport slave (
    input  line_addr_i, line_read_i, line_write_i, line_wdata_i, mem_rdata_i, mem_resp_i,
    output line_rdata_o, line_resp_o, mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
  );

  modport master (
    output line_addr_i, line_read_i, line_write_i, line_wdata_i, mem_rdata_i, mem_resp_i,
    input  line_rdata_o, line_resp_o, mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts one cacheline read/write into a BEATS-beat burst on the memory bus.
// Optional performance counters: define CACHELINE_ADAPTOR_PERF_EN.
module cacheline_burst_adaptor #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  cacheline_burst_adaptor_if.slave bus
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]             perf_rd_lines_o,
  output logic [31:0]             perf_wr_lines_o,
  output logic [31:0]             perf_busy_cycles_o
`endif
);
  localparam int unsigned BEATS    = LINE_W / BURST_W;
  localparam int unsigned OFFSET_W = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W    = $clog2(BEATS);
  localparam logic [31:0] ADDR_MASK = ~32'((1 << OFFSET_W) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   beat_q;
  logic [31:0]        addr_q;
  logic [LINE_W-1:0]  wline_q;
  logic [LINE_W-1:0]  rline_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic               line_resp_q;
  logic               last_beat_c;

  assign last_beat_c = (beat_q == CNT_W'(BEATS - 1));

  // Write line is shifted down one beat per ack, so the current beat is always the low slice.
  assign bus.mem_wdata_o  = wline_q[BURST_W-1:0];
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_read_o   = mem_read_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.line_resp_o  = line_resp_q;
  assign bus.line_rdata_o = rline_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      addr_q      <= '0;
      wline_q     <= '0;
      rline_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      line_resp_q <= 1'b0;
    end else begin
      line_resp_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.line_write_i) begin
            addr_q      <= bus.line_addr_i & ADDR_MASK;
            wline_q     <= bus.line_wdata_i;
            mem_write_q <= 1'b1;
            state_q     <= ST_WRITE;
          end else if (bus.line_read_i) begin
            addr_q     <= bus.line_addr_i & ADDR_MASK;
            mem_read_q <= 1'b1;
            state_q    <= ST_READ;
          end
        end
        ST_READ: begin
          if (bus.mem_resp_i) begin
            rline_q[BURST_W*32'(beat_q) +: BURST_W] <= bus.mem_rdata_i;
            beat_q <= last_beat_c ? '0 : beat_q + CNT_W'(1);
            if (last_beat_c) begin
              mem_read_q  <= 1'b0;
              line_resp_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (bus.mem_resp_i) begin
            wline_q <= wline_q >> BURST_W;
            beat_q  <= last_beat_c ? '0 : beat_q + CNT_W'(1);
            if (last_beat_c) begin
              mem_write_q <= 1'b0;
              line_resp_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic wr_txn_q;

  // Saturating line and busy-cycle counters; the transaction type is remembered for DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_txn_q           <= 1'b0;
      perf_rd_lines_o    <= '0;
      perf_wr_lines_o    <= '0;
      perf_busy_cycles_o <= '0;
    end else begin
      if (state_q == ST_WRITE) wr_txn_q <= 1'b1;
      else if (state_q == ST_READ) wr_txn_q <= 1'b0;
      if (state_q != ST_IDLE && perf_busy_cycles_o != '1)
        perf_busy_cycles_o <= perf_busy_cycles_o + 32'd1;
      if (state_q == ST_DONE) begin
        if (wr_txn_q && perf_wr_lines_o != '1) perf_wr_lines_o <= perf_wr_lines_o + 32'd1;
        if (!wr_txn_q && perf_rd_lines_o != '1) perf_rd_lines_o <= perf_rd_lines_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Sits directly downstream of the instruction/data caches' physical-memory port.
- Converts one 256-bit cacheline read or write request into a 4-beat 64-bit burst on the main-memory bus.
- Returns a single-cycle line-level response to the cache.
- One outstanding transaction at a time; new requests are accepted only in IDLE.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory data-bus width in bits; LINE_W must be an integer multiple of it.
- BEATS, LINE_W/BURST_W (4), beats per line; derived, not overridden.
- OFFSET_W, $clog2(LINE_W/8) (5), address bits cleared for line alignment; derived.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset: 0 resets, 1 runs.
- line_addr_i  in  32  cache request address (any byte address within the line).
- line_read_i  in  1  cache line read request.
- line_write_i  in  1  cache line write request.
- line_wdata_i  in  LINE_W  line to write; sampled on acceptance.
- line_rdata_o  out  LINE_W  assembled read line.
- line_resp_o  out  1  one-cycle completion pulse to the cache.
- mem_addr_o  out  32  line-aligned burst address.
- mem_read_o  out  1  burst read request.
- mem_write_o  out  1  burst write request.
- mem_wdata_o  out  BURST_W  current write beat.
- mem_rdata_i  in  BURST_W  read beat data; valid when mem_resp_i=1.
- mem_resp_i  in  1  per-beat handshake: read data valid, or write beat consumed.

Behaviour:
- Reset (rst=0, async): state=IDLE, beat counter=0, all outputs 0 including line_rdata_o. Asserting reset mid-burst drops mem_read_o/mem_write_o immediately and discards the partial line. No line_resp_o is produced for the aborted transaction.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If line_write_i=1, latch the address and line_wdata_i, go to WRITE.
  - Else if line_read_i=1, latch the address, go to READ.
  - Write has priority when both requests are high; the read is not latched.
  - Requests arriving in any other state are ignored.
- Address: mem_addr_o = {latched_addr[31:OFFSET_W], OFFSET_W'b0}. Held constant from acceptance through DONE.
- READ:
  - mem_read_o=1 continuously.
  - Each cycle with mem_resp_i=1 stores mem_rdata_i into line bits [BURST_W*beat +: BURST_W] and increments beat.
  - Gaps (mem_resp_i=0) are allowed; the counter holds.
  - The cycle in which beat BEATS-1 is captured deasserts mem_read_o on the next edge and moves to DONE.
- WRITE:
  - mem_write_o=1.
  - mem_wdata_o = latched line bits [BURST_W*beat +: BURST_W].
  - Beat advances on mem_resp_i=1; after beat BEATS-1 is consumed, go to DONE.
- DONE: line_resp_o=1 for exactly one cycle, then IDLE. The earliest next acceptance is the cycle after DONE.
- Latency: read of 4 back-to-back beats means the request is accepted at cycle 0, beats arrive at cycles 1–4, and line_resp_o is high at cycle 5.
- line_rdata_o:
  - Updates only on read beats.
  - Holds its last complete line until the next read overwrites it beat by beat.
  - Valid to the cache only in the line_resp_o cycle.
  - Write transactions do not modify it.
- Request withdrawal: if the cache drops line_read_i/line_write_i mid-burst, the burst still completes and line_resp_o still pulses.
- mem_resp_i in IDLE/DONE: ignored.
- Beat counter is $clog2(BEATS) bits. It wraps to 0 on the last beat and never exceeds BEATS-1.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_PERF_EN.
- When defined, three 32-bit outputs are added:
  - perf_rd_lines_o: completed reads.
  - perf_wr_lines_o: completed writes.
  - perf_busy_cycles_o: cycles not in IDLE.
- Counters saturate at 32'hFFFF_FFFF and are cleared by reset. Reads and writes increment in the DONE cycle.
- When undefined, the ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset then idle: rst=0 mid-run -> all outputs 0 asynchronously; after release, no mem_read_o/mem_write_o until a request.
- Read, back-to-back beats:
  - Stimulus: line_read_i=1, addr=32'h0000_1234; beats 64'hA0..A3 on 4 consecutive mem_resp_i.
  - Response: mem_addr_o=32'h0000_1220; line_resp_o high for 1 cycle at cycle 5; line_rdata_o={A3,A2,A1,A0}.
- Read with gaps:
  - Stimulus: mem_resp_i pattern 1,0,0,1,1,0,1.
  - Response: counter holds on 0s; exactly 4 beats captured in order; single line_resp_o pulse.
- Write:
  - Stimulus: line_wdata_i=256'h{D3,D2,D1,D0}, addr=32'h8000_003C.
  - Response: mem_addr_o=32'h8000_0020; mem_wdata_o=D0,D1,D2,D3 on successive acks; line_rdata_o unchanged.
- Simultaneous read+write in IDLE -> write burst only. Read request asserted during the burst is ignored until after DONE; held high, it is accepted the cycle after DONE.
- Reset asserted after 2 read beats -> mem_read_o=0 immediately, no line_resp_o. A subsequent full read returns a correct line with no stale beats.
